psum_accumulator: RTL and testbench

- Downstream stage of fusion_unit; consumes its 52-bit psum_fwd bus.
- Sums a configured number of consecutive psum beats per output, either as four 13-bit lanes or as one 32-bit scalar.
- Emits the final sums on a valid/ready port toward the output buffer.
- Sits between the fusion-unit column tail and writeback.

---
 rtl/fusion_pkg.sv | 17 +
 rtl/sat_add_lane.sv | 18 +
 rtl/psum_accumulator.sv | 78 +++++++
 tb/tb_psum_accumulator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// fusion_pkg: shared widths, FSM states and psum lane extraction for the fusion datapath
package fusion_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 13;
  localparam int PSUM_W = LANES * LANE_W;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  // Split mode yields 13-bit lane i extended to ACC_W; scalar mode puts psum[31:0] on lane 0 and zeros elsewhere
  function automatic logic [ACC_W-1:0] lane_slice(input logic [PSUM_W-1:0] p, input int i,
                                                  input logic split, input logic sgn);
    logic [LANE_W-1:0] l;
    l = p[LANE_W*i +: LANE_W];
    if (!split) return (i == 0) ? p[ACC_W-1:0] : '0;
    return sgn ? {{(ACC_W-LANE_W){l[LANE_W-1]}}, l} : {{(ACC_W-LANE_W){1'b0}}, l};
  endfunction
endpackage

// File: rtl/sat_add_lane.sv
// sat_add_lane: ACC_W saturating adder, signed or unsigned, with overflow flag
module sat_add_lane
  import fusion_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sgn,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W:0] s;
  // One extra bit of headroom; its disagreement with the MSB (signed) or its carry (unsigned) marks overflow
  always_comb begin
    s = {sgn & a[ACC_W-1], a} + {sgn & b[ACC_W-1], b};
    ovf = sgn ? (s[ACC_W] ^ s[ACC_W-1]) : s[ACC_W];
    sum = !ovf ? s[ACC_W-1:0] : sgn ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : '1;
  end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums cfg_len psum beats per result as four 13-bit lanes or one 32-bit scalar
module psum_accumulator
  import fusion_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cfg_split,
  input  logic                   cfg_signed,
  input  logic [CNT_W-1:0]       cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PSUM_W-1:0]      psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   busy,
  output logic                   ovf
);
  state_t state, state_nxt;
  logic split_q, signed_q;
  logic [CNT_W-1:0] len_q, cnt;
  logic [LANES-1:0][ACC_W-1:0] acc, sum;
  logic [LANES-1:0] lane_ovf;
  logic beat, last;
  assign beat = in_valid & in_ready;
  assign last = CNT_W'(cnt + 1'b1) == ((len_q == '0) ? CNT_W'(1) : len_q);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_add_lane u_add (
      .a   (acc[k]),
      .b   (lane_slice(psum_in, k, split_q, signed_q)),
      .sgn (signed_q),
      .sum (sum[k]),
      .ovf (lane_ovf[k])
    );
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // Next state: start only honoured in IDLE, result leaves on the output handshake
  always_comb begin
    state_nxt = (state == IDLE)  ? (start ? ACCUM : IDLE) :
                (state == ACCUM) ? ((beat && last) ? OUTPUT : ACCUM) :
                (out_ready ? IDLE : OUTPUT);
  end
  // Handshake and status outputs decode directly from state
  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == OUTPUT;
    busy      = state != IDLE;
  end
  // Datapath: config latch on start, accumulate on each accepted beat, capture the final sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q  <= 1'b0;
      signed_q <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else if (state == IDLE && start) begin
      split_q  <= cfg_split;
      signed_q <= cfg_signed;
      len_q    <= cfg_len;
      cnt      <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else if (beat) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      ovf <= ovf | (|lane_ovf);
      if (last) out_data <= sum;
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: scoreboard bench with directed vectors for psum_accumulator
module tb_psum_accumulator;
  import fusion_pkg::*;
  typedef struct { logic [LANES*ACC_W-1:0] d; logic o; } exp_t;
  logic clk = 0, rst = 1, start = 0, cfg_split = 0, cfg_signed = 0, in_valid = 0, out_ready = 0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic in_ready, out_valid, busy, ovf;
  logic [LANES*ACC_W-1:0] out_data;
  exp_t sb[$];
  int checks = 0, failures = 0;
  psum_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .cfg_split(cfg_split), .cfg_signed(cfg_signed),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [LANES*ACC_W-1:0] act, input logic [LANES*ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.d || ovf !== e.o) begin
          failures++;
          $display("FAIL result actual=%h/ovf%b expected=%h/ovf%b", out_data, ovf, e.d, e.o);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic sp, input logic sg, input logic [CNT_W-1:0] len);
    start = 1; cfg_split = sp; cfg_signed = sg; cfg_len = len;
    step();
    start = 0;
  endtask
  task automatic beat(input logic [PSUM_W-1:0] p);
    in_valid = 1; psum_in = p;
    step();
    in_valid = 0;
  endtask
  task automatic push(input logic [LANES*ACC_W-1:0] d, input logic o);
    exp_t e;
    e.d = d; e.o = o;
    sb.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) chk("drain_timeout", {127'd0, out_valid}, 128'd1);
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
  initial begin
    logic [LANES*ACC_W-1:0] neg4;
    neg4 = {4{32'hFFFFFFFC}};
    step(); step();
    rst = 0;
    step();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ovf", {127'd0, ovf}, 128'd0);
    // split unsigned, 3 beats
    push({32'd54, 32'd36, 32'd18, 32'd0}, 1'b0);
    do_start(1, 0, 16'd3);
    chk("accum_in_ready", {127'd0, in_ready}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      beat({13'd18, 13'd12, 13'd6, 13'd0});
      chk("split_latency_valid", {127'd0, out_valid}, {127'd0, i == 2});
    end
    chk("output_in_ready", {127'd0, in_ready}, 128'd0);
    drain();
    chk("split_idle_busy", {127'd0, busy}, 128'd0);
    // scalar signed; upper bits junk must be ignored
    push({96'd0, 32'hFFFFFF01}, 1'b0);
    do_start(0, 1, 16'd2);
    beat({20'hABCDE, 32'hFFFFC000});
    beat({20'h12345, 32'h00003F01});
    drain();
    // signed saturation
    push({96'd0, 32'h7FFFFFFF}, 1'b1);
    do_start(0, 1, 16'd2);
    beat({20'd0, 32'h7FFFFFFF});
    beat({20'd0, 32'h00000001});
    chk("sat_signed_ovf", {127'd0, ovf}, 128'd1);
    drain();
    // unsigned saturation; start clears ovf
    push({96'd0, 32'hFFFFFFFF}, 1'b1);
    do_start(0, 0, 16'd2);
    chk("start_clears_ovf", {127'd0, ovf}, 128'd0);
    beat({20'd0, 32'hFFFFFFFF});
    beat({20'd0, 32'h00000001});
    drain();
    // split signed, gapped in_valid, then backpressure
    push(neg4, 1'b0);
    do_start(1, 1, 16'd4);
    for (int i = 0; i < 4; i++) begin
      beat({4{13'h1FFF}});
      chk("gap_valid", {127'd0, out_valid}, {127'd0, i == 3});
      if (i < 3) begin
        step();
        chk("gap_stall_valid", {127'd0, out_valid}, 128'd0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_out_data", out_data, neg4);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    drain();
    chk("bp_idle_busy", {127'd0, busy}, 128'd0);
    chk("bp_idle_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_hold_data", out_data, neg4);
    // reset mid-accumulation
    do_start(1, 0, 16'd4);
    beat({4{13'd1}});
    beat({4{13'd1}});
    rst = 1;
    #1;
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("midrst_out_data", out_data, 128'd0);
    step();
    rst = 0;
    step();
    // cfg_len=0 acts as 1
    push({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    do_start(1, 0, 16'd0);
    beat({13'd4, 13'd3, 13'd2, 13'd1});
    chk("len0_valid", {127'd0, out_valid}, 128'd1);
    drain();
    // start during ACCUM is ignored
    push({96'd0, 32'd12}, 1'b0);
    do_start(0, 0, 16'd2);
    beat({20'd0, 32'd5});
    do_start(1, 1, 16'd0);
    chk("ign_start_busy", {127'd0, busy}, 128'd1);
    chk("ign_start_valid", {127'd0, out_valid}, 128'd0);
    beat({20'd0, 32'd7});
    drain();
    step();
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
